// File: rtl/ccff_chain_loader.sv
// Streams configuration words LSB-first into a CCFF chain and reports done after CHAIN_LEN bits.
// Define CCFF_READBACK_EN to add a full-chain rotation with a ones-count integrity check.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WB_ZERO  = {WB_W{1'b0}};
  localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);
  localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(WORD_W - 1);

`ifdef CCFF_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic [WORD_W-1:0]  sh_r, sh_nxt_s;
  logic [WB_W-1:0]    wb_r, wb_nxt_s;     // bits still waiting in sh_r (head_r holds the current one)
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               head_r, head_nxt_s;
  logic               shen_r, shen_nxt_s;
  logic               ready_r, ready_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               error_r, error_nxt_s;
  logic               accept_s;

`ifdef CCFF_READBACK_EN
  logic [CNT_W-1:0]   ones_ld_r, ones_ld_nxt_s;
  logic [CNT_W-1:0]   ones_chk_r, ones_chk_nxt_s;
  logic               match_s;
  assign match_s = ((ones_chk_r + CNT_W'(ccff_tail)) == ones_ld_r);
`endif

  assign accept_s = cfg_valid && ready_r;

  // State register
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = IDLE;
      end
      LOAD: begin
        if (abort)                 state_nxt_s = IDLE;
`ifdef CCFF_READBACK_EN
        else if (cnt_r == CNT_MAX) state_nxt_s = CHECK;
`else
        else if (cnt_r == CNT_MAX) state_nxt_s = DONE;
`endif
        else                       state_nxt_s = LOAD;
      end
`ifdef CCFF_READBACK_EN
      CHECK: begin
        if (abort)                              state_nxt_s = IDLE;
        else if (shen_r && (cnt_r == CNT_LAST)) state_nxt_s = match_s ? DONE : IDLE;
        else                                    state_nxt_s = CHECK;
      end
`endif
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sh_nxt_s    = sh_r;
    wb_nxt_s    = wb_r;
    cnt_nxt_s   = cnt_r;
    head_nxt_s  = head_r;
    shen_nxt_s  = 1'b0;
    error_nxt_s = error_r;
`ifdef CCFF_READBACK_EN
    ones_ld_nxt_s  = ones_ld_r;
    ones_chk_nxt_s = ones_chk_r;
`endif
    case (state_r)
      IDLE: begin
        sh_nxt_s   = {WORD_W{1'b0}};
        wb_nxt_s   = WB_ZERO;
        cnt_nxt_s  = CNT_ZERO;
        head_nxt_s = 1'b0;
`ifdef CCFF_READBACK_EN
        ones_ld_nxt_s = CNT_ZERO;
`endif
        if (start) error_nxt_s = 1'b0;
        else       error_nxt_s = error_r;
      end
      LOAD: begin
        if (abort) begin
          error_nxt_s = 1'b1;
          wb_nxt_s    = WB_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          // Whatever is left of a partial last word is dropped here.
          wb_nxt_s = WB_ZERO;
`ifdef CCFF_READBACK_EN
          cnt_nxt_s      = CNT_ZERO;
          ones_chk_nxt_s = CNT_ZERO;
`endif
        end else if (wb_r != WB_ZERO) begin
          head_nxt_s = sh_r[0];
          sh_nxt_s   = sh_r >> 1'b1;
          wb_nxt_s   = wb_r - WB_ONE;
          shen_nxt_s = 1'b1;
          cnt_nxt_s  = cnt_r + CNT_ONE;
`ifdef CCFF_READBACK_EN
          ones_ld_nxt_s = ones_ld_r + CNT_W'(sh_r[0]);
`endif
        end else if (accept_s) begin
          head_nxt_s = cfg_data[0];
          sh_nxt_s   = cfg_data >> 1'b1;
          wb_nxt_s   = WB_FULL;
          shen_nxt_s = 1'b1;
          cnt_nxt_s  = cnt_r + CNT_ONE;
`ifdef CCFF_READBACK_EN
          ones_ld_nxt_s = ones_ld_r + CNT_W'(cfg_data[0]);
`endif
        end else begin
          shen_nxt_s = 1'b0;
        end
      end
`ifdef CCFF_READBACK_EN
      CHECK: begin
        if (abort) begin
          error_nxt_s = 1'b1;
        end else begin
          // First CHECK cycle only primes head_r with the tail bit, so the rotation closes on CHAIN_LEN shifts.
          head_nxt_s = ccff_tail;
          if (!shen_r) begin
            shen_nxt_s = 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            shen_nxt_s  = 1'b0;
            error_nxt_s = error_r | ~match_s;
          end else begin
            shen_nxt_s     = 1'b1;
            cnt_nxt_s      = cnt_r + CNT_ONE;
            ones_chk_nxt_s = ones_chk_r + CNT_W'(ccff_tail);
          end
        end
      end
`endif
      DONE: begin
        if (abort) error_nxt_s = 1'b1;
        else       error_nxt_s = error_r;
      end
      default: begin
        shen_nxt_s = 1'b0;
      end
    endcase
  end

  assign ready_nxt_s = (state_nxt_s == LOAD) && (wb_nxt_s == WB_ZERO) && (cnt_nxt_s != CNT_MAX);
  assign busy_nxt_s  = (state_nxt_s != IDLE);
  assign done_nxt_s  = (state_nxt_s == DONE);

  // Datapath and output registers
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      sh_r    <= {WORD_W{1'b0}};
      wb_r    <= WB_ZERO;
      cnt_r   <= CNT_ZERO;
      head_r  <= 1'b0;
      shen_r  <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      sh_r    <= sh_nxt_s;
      wb_r    <= wb_nxt_s;
      cnt_r   <= cnt_nxt_s;
      head_r  <= head_nxt_s;
      shen_r  <= shen_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      error_r <= error_nxt_s;
    end
  end

`ifdef CCFF_READBACK_EN
  // Ones counters for the readback comparison
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      ones_ld_r  <= CNT_ZERO;
      ones_chk_r <= CNT_ZERO;
    end else begin
      ones_ld_r  <= ones_ld_nxt_s;
      ones_chk_r <= ones_chk_nxt_s;
    end
  end
`endif

  assign cfg_ready     = ready_r;
  assign ccff_head     = head_r;
  assign ccff_shift_en = shen_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 20-bit behavioural chain on ccff_head/ccff_tail.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
  localparam int L = 20;
  localparam int W = 8;
`ifdef CCFF_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic         prog_clk  = 1'b0;
  logic         reset     = 1'b1;
  logic         start     = 1'b0;
  logic         abort     = 1'b0;
  logic [W-1:0] cfg_data  = 8'h00;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .reset(reset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: position 0 next to head, position L-1 drives tail
  logic [L-1:0] chain = 20'h00000;
  logic         force_tail0 = 1'b0;
  assign ccff_tail = force_tail0 ? 1'b0 : chain[L-1];
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
  end

  // Stream monitor sampled on the falling edge
  int          n_shift = 0, n_done = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  logic [63:0] stream = 64'h0;
  logic        mon_clr = 1'b0;
  always @(negedge prog_clk) begin
    if (mon_clr) begin
      n_shift <= 0; n_done <= 0; cyc <= 0; first_cyc <= -1; last_cyc <= -1; stream <= 64'h0;
    end else begin
      cyc <= cyc + 1;
      if (ccff_shift_en) begin
        if (first_cyc < 0) first_cyc <= cyc;
        last_cyc <= cyc;
        if (n_shift < 64) stream[n_shift] <= ccff_head;
        n_shift <= n_shift + 1;
      end
      if (done) n_done <= n_done + 1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s_timeout actual=expired expected=event", name);
  endtask

  task automatic clear_mon();
    @(posedge prog_clk); mon_clr = 1'b1;
    @(posedge prog_clk); mon_clr = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int g = 0;
    while (!cfg_ready && g < 100) begin @(negedge prog_clk); g++; end
    if (g >= 100) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 200) begin @(negedge prog_clk); g++; end
    if (g >= 200) timeout_fail(name);
  endtask

  task automatic wait_shifts(input int n, input string name);
    int g = 0;
    while (n_shift < n && g < 100) begin @(negedge prog_clk); g++; end
    if (g >= 100) timeout_fail(name);
  endtask

  task automatic pulse_start();
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    logic        mid_start;
    logic [19:0] exp_stream;
    int          exp_span;
  } vec_t;

  vec_t vecs[5];

  task automatic run_load(input vec_t v, input string tag);
    logic [7:0]   words[3];
    logic [L-1:0] rev;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    clear_mon();
    pulse_start();
    chk($sformatf("%s_start_busy_ready", tag), 64'({busy, cfg_ready}), 64'(2'b11));
    for (int i = 0; i < 3; i++) begin
      if (i > 0 && v.gap > 0) begin
        cfg_valid = 1'b0;
        wait_ready(tag);
        repeat (v.gap) @(negedge prog_clk);
      end
      cfg_valid = 1'b1;
      cfg_data  = words[i];
      wait_ready(tag);
      @(negedge prog_clk);
      if (v.mid_start && i == 0) begin
        start = 1'b1; @(negedge prog_clk); start = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    wait_idle(tag);
    repeat (2) @(negedge prog_clk);
    chk($sformatf("%s_shifts", tag), 64'(n_shift), 64'(L + RB * L));
    chk($sformatf("%s_stream", tag), 64'(stream[19:0]), 64'(v.exp_stream));
    chk($sformatf("%s_span", tag), 64'(last_cyc - first_cyc + 1), 64'(v.exp_span + RB * (L + 1)));
    chk($sformatf("%s_done", tag), 64'(n_done), 64'(1));
    chk($sformatf("%s_error", tag), 64'(error), 64'(0));
    chk($sformatf("%s_idle", tag), 64'({busy, cfg_ready, ccff_shift_en}), 64'(3'b000));
    for (int k = 0; k < L; k++) rev[L-1-k] = v.exp_stream[k];
    if (RB == 1) chk($sformatf("%s_chain", tag), 64'(chain), 64'(rev));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 20'hF3CA5, 20};
    vecs[1] = '{8'hA5, 8'h3C, 8'h0F, 3, 1'b0, 20'hF3CA5, 26};
    vecs[2] = '{8'hFF, 8'h00, 8'h81, 1, 1'b0, 20'h100FF, 22};
    vecs[3] = '{8'h5A, 8'hC3, 8'hF0, 2, 1'b0, 20'h0C35A, 24};
    vecs[4] = '{8'hA5, 8'h3C, 8'h0F, 0, 1'b1, 20'hF3CA5, 20};

    #1 reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("reset_outputs", 64'({cfg_ready, ccff_head, ccff_shift_en, busy, done, error}), 64'(6'b0));
    reset = 1'b1;
    repeat (2) @(negedge prog_clk);
    chk("idle_after_reset", 64'({busy, cfg_ready, done, error}), 64'(4'b0));

    for (int t = 0; t < 5; t++) run_load(vecs[t], $sformatf("vec%0d", t));

    // Abort after nine shifted bits
    clear_mon();
    pulse_start();
    cfg_valid = 1'b1; cfg_data = 8'hA5;
    wait_shifts(9, "abort");
    abort = 1'b1;
    @(negedge prog_clk); abort = 1'b0;
    chk("abort_state", 64'({busy, error, ccff_shift_en, cfg_ready}), 64'(4'b0100));
    cfg_valid = 1'b0;
    repeat (4) @(negedge prog_clk);
    chk("abort_shifts", 64'(n_shift), 64'(10));
    chk("abort_no_done", 64'(n_done), 64'(0));
    chk("abort_error_sticky", 64'(error), 64'(1));
    pulse_start();
    chk("abort_start_clears", 64'({error, busy}), 64'(2'b01));
    cfg_valid = 1'b1;
    wait_idle("abort_reload");
    cfg_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("abort_reload_done", 64'(n_done), 64'(1));
    chk("abort_reload_error", 64'(error), 64'(0));

    // Reset in the middle of a load
    clear_mon();
    pulse_start();
    cfg_valid = 1'b1; cfg_data = 8'hA5;
    wait_shifts(5, "midreset");
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 64'({cfg_ready, ccff_head, ccff_shift_en, busy, done, error}), 64'(6'b0));
    cfg_valid = 1'b0;
    @(negedge prog_clk); reset = 1'b1;
    run_load(vecs[0], "post_reset");

    if (RB == 1) begin
      // Broken chain: tail stuck low
      force_tail0 = 1'b1;
      clear_mon();
      pulse_start();
      cfg_valid = 1'b1; cfg_data = 8'hA5;
      wait_idle("rb_tail0");
      cfg_valid = 1'b0;
      repeat (2) @(negedge prog_clk);
      chk("rb_tail0_error", 64'(error), 64'(1));
      chk("rb_tail0_no_done", 64'(n_done), 64'(0));
      force_tail0 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
